// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped debug UART transmitter:
// register offsets, STATUS bit positions and serialiser state encoding.
package mmio_uart_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped debug UART transmitter: CPU stores to TXDATA are queued in a
// FIFO and serialised as 8N1 frames; STATUS exposes busy/empty/full/overflow/count.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); pops the next byte on its last cycle
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int CNTW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUDW = $clog2(CLKS_PER_BIT);
  localparam logic [BAUDW-1:0] BAUD_LAST = BAUDW'(CLKS_PER_BIT - 1);

  logic [1:0]       state_q, state_d;
  logic [BAUDW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNTW-1:0]  fifo_count;
  logic             ovf_set, ovf_clr;
  logic             unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:8];

  assign fifo_push = we && (addr == UART_TXDATA);
  assign ovf_set   = fifo_push && fifo_full;
  assign ovf_clr   = we && (addr == UART_STATUS) && wdata[STAT_OVF];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

  // Sticky overflow: a rejected push in the same cycle as a clear leaves it set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Serialiser next-state; baud timer is a down-counter reloaded at each bit boundary.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = BAUD_LAST;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BAUDW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q - BAUDW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            baud_d   = BAUD_LAST;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUDW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx changes on the same edge as the FSM.
  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // Serialiser and overflow registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Register read mux; count is zero-extended into an 8-bit field (a 256-deep full
  // queue reads count 0 there, with the full bit set).
  always_comb begin
    rdata = '0;
    if (addr == UART_STATUS) begin
      rdata[STAT_BUSY]            = busy;
      rdata[STAT_EMPTY]           = fifo_empty;
      rdata[STAT_FULL]            = fifo_full;
      rdata[STAT_OVF]             = ovf_q;
      rdata[STAT_CNT_LSB +: 8]    = 8'(fifo_count);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vectors, hand-built frame
// sequences and randomized traffic against a frame-level reference model.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted bytes, the current frame's start edge and
  // byte, and the earliest edge at which the next byte may leave the queue.
  logic [7:0] mq[$];
  int         cyc = 0;
  int         free_at = 0;
  int         fr_s = -1000;
  logic [7:0] fr_b = 8'h00;
  logic       m_ovf = 1'b0;

  logic [31:0] last_rd;
  logic        last_tx;
  logic        last_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic m_in_frame();
    return (cyc >= fr_s) && (cyc - fr_s < FRAME);
  endfunction

  function automatic logic m_busy();
    return m_in_frame() || (mq.size() > 0);
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_in_frame()) return 1'b1;
    k = (cyc - fr_s) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return fr_b[k-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 4'h4) begin
      r[0]    = m_busy();
      r[1]    = (mq.size() == 0);
      r[2]    = (mq.size() == DEPTH);
      r[3]    = m_ovf;
      r[15:8] = 8'(mq.size());
    end
    return r;
  endfunction

  task automatic m_edge(input logic w, input logic [3:0] a, input logic [31:0] d);
    int   pre;
    logic set, clr;
    cyc++;
    pre = mq.size();
    if (cyc >= free_at && pre > 0) begin
      fr_b    = mq.pop_front();
      fr_s    = cyc;
      free_at = cyc + FRAME;
    end
    set = 1'b0;
    if (w && a == 4'h0) begin
      if (pre < DEPTH) mq.push_back(d[7:0]);
      else set = 1'b1;
    end
    clr = w && (a == 4'h4) && d[3];
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic m_reset();
    mq.delete();
    free_at = 0;
    fr_s    = -1000;
    m_ovf   = 1'b0;
  endtask

  // One clock: drive at negedge, check combinational read, clock, check line.
  task automatic step(input logic w, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; addr = a; wdata = d;
    #1;
    last_rd = rdata;
    chk("rdata", rdata, m_read(a));
    @(posedge clk);
    m_edge(w, a, d);
    #1;
    we = 1'b0;
    last_tx   = tx;
    last_busy = busy;
    chk("tx", {31'b0, tx}, {31'b0, m_tx()});
    chk("busy", {31'b0, busy}, {31'b0, m_busy()});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h4, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    we = 1'b0; addr = 4'h4; wdata = '0;
    reset = 1'b1;
    #1;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_status", rdata, 32'h0000_0002);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] e_rd;
    logic        e_tx;
    logic        e_busy;
  } vec_t;

  vec_t        vecs[8];
  logic        txs[FRAME+1];
  logic        bss[FRAME+1];
  logic [9:0]  pat;
  int          gaps;
  int          lows;

  initial begin
    // e_rd is sampled before the edge, e_tx/e_busy after it.
    vecs[0] = '{"rd_status",  1'b0, 4'h4, 32'h0,        32'h0000_0002, 1'b1, 1'b0};
    vecs[1] = '{"rd_8",       1'b0, 4'h8, 32'h0,        32'h0,         1'b1, 1'b0};
    vecs[2] = '{"wr_c",       1'b1, 4'hC, 32'hFF,       32'h0,         1'b1, 1'b0};
    vecs[3] = '{"rd_txdata",  1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0};
    vecs[4] = '{"clr_ovf",    1'b1, 4'h4, 32'h8,        32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{"push_a5",    1'b1, 4'h0, 32'hFFFF_FFA5, 32'h0,        1'b1, 1'b1};
    vecs[6] = '{"cnt1_pop",   1'b0, 4'h4, 32'h0,        32'h0000_0101, 1'b0, 1'b1};
    vecs[7] = '{"cnt0_start", 1'b0, 4'h4, 32'h0,        32'h0000_0003, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].w, vecs[i].a, vecs[i].d);
      chk({vecs[i].name, "_rd"}, last_rd, vecs[i].e_rd);
      chk({vecs[i].name, "_tx"}, {31'b0, last_tx}, {31'b0, vecs[i].e_tx});
      chk({vecs[i].name, "_busy"}, {31'b0, last_busy}, {31'b0, vecs[i].e_busy});
    end

    // Single 0xA5 frame: start, LSB-first data, stop; busy drops after 40 cycles.
    do_reset();
    wr(4'h0, 32'hA5);
    for (int i = 0; i <= FRAME; i++) begin
      step(1'b0, 4'h4, 32'h0);
      txs[i] = last_tx;
      bss[i] = last_busy;
    end
    pat = 10'b11_0100_1010;
    chk("a5_fall", {31'b0, txs[0]}, 32'd0);
    for (int k = 0; k < 10; k++)
      chk("a5_bit", {31'b0, txs[k*CPB + 2]}, {31'b0, pat[k]});
    chk("a5_busy_last", {31'b0, bss[FRAME-1]}, 32'd1);
    chk("a5_busy_drop", {31'b0, bss[FRAME]}, 32'd0);

    // Three back-to-back bytes form contiguous frames.
    do_reset();
    wr(4'h0, 32'h55);
    wr(4'h0, 32'h0F);
    wr(4'h0, 32'h33);
    step(1'b0, 4'h4, 32'h0);
    chk("b2b_count", {24'b0, last_rd[15:8]}, 32'd2);
    gaps = 0;
    for (int i = 0; i < 3*FRAME - 3; i++) begin
      step(1'b0, 4'h4, 32'h0);
      if (!last_busy) gaps++;
    end
    chk("b2b_gaps", gaps, 32'd0);
    step(1'b0, 4'h4, 32'h0);
    chk("b2b_done", {31'b0, last_busy}, 32'd0);

    // Overflow while a frame is in flight; 0xEE must never reach the line.
    do_reset();
    wr(4'h0, 32'h11);
    wr(4'h0, 32'h21);
    wr(4'h0, 32'h22);
    wr(4'h0, 32'h23);
    wr(4'h0, 32'h24);
    wr(4'h0, 32'hEE);
    step(1'b0, 4'h4, 32'h0);
    chk("ovf_status", last_rd, 32'h0000_040D);
    wr(4'h4, 32'h8);
    step(1'b0, 4'h4, 32'h0);
    chk("ovf_cleared", last_rd, 32'h0000_0405);
    idle(5*FRAME + 10);

    // Reset during DATA of the second queued byte.
    do_reset();
    wr(4'h0, 32'hC3);
    wr(4'h0, 32'h00);
    idle(FRAME + 10);
    chk("pre_rst_tx", {31'b0, last_tx}, 32'd0);
    do_reset();
    lows = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      step(1'b0, 4'h4, 32'h0);
      if (!last_tx) lows++;
    end
    chk("post_rst_quiet", lows, 32'd0);

    // Push landing on the STOP-end pop with two bytes queued.
    do_reset();
    wr(4'h0, 32'h81);
    wr(4'h0, 32'h42);
    wr(4'h0, 32'h24);
    idle(FRAME - 2);
    wr(4'h0, 32'h99);
    step(1'b0, 4'h4, 32'h0);
    chk("stop_push_cnt", {24'b0, last_rd[15:8]}, 32'd2);
    idle(4*FRAME);

    // Randomized traffic: dense phase (overflows), then sparse phase (idle gaps).
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      int r;
      r = (i < 500) ? $urandom_range(0, 9) : $urandom_range(0, 59);
      case (r)
        0, 1, 2: wr(4'h0, $urandom);
        3:       wr(4'h4, $urandom);
        4:       wr(($urandom_range(0, 1) == 0) ? 4'h8 : 4'hC, $urandom);
        default: step(1'b0, 4'(4 * $urandom_range(0, 3)), 32'h0);
      endcase
    end
    idle(6*FRAME);
    chk("drain_busy", {31'b0, last_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped debug UART transmitter sitting directly downstream of the `riscv_multi` store path: the CPU writes bytes into a TXDATA register, and the block queues them and serialises them as 8N1 frames on the board's TX line. It replaces the ad-hoc counter-driven `uart_tx` hookup with a buffered, CPU-visible peripheral that exposes status back to software.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit (12 MHz / 115200 baud); legal range ≥ 2.
- `FIFO_DEPTH`, default 16: byte queue depth; power of two, 2..256.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (CLK12MHZ domain).
- `reset`  in  1  asynchronous, active-high reset.
- `we`  in  1  CPU write strobe, one cycle per store.
- `addr`  in  4  word-aligned register offset.
- `wdata`  in  32  store data.
- `rdata`  out  32  combinational read data for `addr`.
- `tx`  out  1  serial output, registered, idle high.
- `busy`  out  1  high while a frame is in flight or the FIFO is non-empty.

## Operation
- Register map:
  - 0x0 TXDATA (write): push `wdata[7:0]`; reads return 0.
  - 0x4 STATUS (read): [0] busy, [1] empty, [2] full, [3] overflow, [15:8] count, others 0. Writing with `wdata[3]`=1 clears overflow.
  - Any other offset reads 0 and ignores writes.
- Push: `we` && `addr`==0x0 && !full → byte stored, count+1. When full, the byte is dropped, count is unchanged, and overflow is set (sticky). A push at full is rejected even if a pop happens in the same cycle.
- Overflow set and clear in the same cycle: set wins.
- Serialiser FSM:
  - IDLE: tx=1. If FIFO non-empty, pop into the shift register and go to START.
  - START: tx=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each; 3-bit bit index wraps 7→0, then STOP.
  - STOP: tx=1 for `CLKS_PER_BIT` cycles. On the last cycle, if the FIFO is non-empty, pop and go to START (no idle gap); otherwise go to IDLE.
- Push and pop in the same cycle when not full: count unchanged, both take effect.
- The FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. count is `$clog2(FIFO_DEPTH)+1` bits, zero-extended into STATUS[15:8].
- `busy` = (state≠IDLE) | !empty.

## Timing
- Reset values: `tx`=1, `busy`=0, state=IDLE, count=0, pointers=0, overflow=0, baud counter=0, bit index=0. `rdata` follows `addr` combinationally and reads STATUS as 0x0000_0002 after reset.
- Reset mid-frame: `tx` returns to 1 asynchronously and all queued bytes are discarded.
- Latency from a TXDATA write into an empty, idle block:
  - Write sampled at edge N: count=1 after N.
  - Pop at edge N+1: `tx` falls after N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- STATUS reflects register state after the most recent edge; a read in the same cycle as a push shows the pre-push count.

## Structure
- Package `mmio_uart_pkg`: address constants `UART_TXDATA`=4'h0 and `UART_STATUS`=4'h4, STATUS bit-position constants, and the serialiser state encoding (IDLE/START/DATA/STOP, 2 bits).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count). The top level holds the register decode, overflow flag and serialiser FSM.

## Test plan
Run with `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- Reset, then read 0x4 → `rdata`=0x0000_0002; `tx`=1; `busy`=0.
- Write 0xA5 to 0x0 → `tx` falls 2 edges later. Sampled bits are 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop), each 4 cycles. `busy` drops after 40 cycles.
- Write 0x55, 0x0F, 0x33 back-to-back → three contiguous 40-cycle frames with no idle cycle between them; count reads 2 one cycle after the third write.
- While a frame is in flight, fill the FIFO to 4 and write a 5th byte 0xEE → STATUS full=1, overflow=1, count=4; 0xEE is never transmitted. Write 0x8 to 0x4 → overflow=0.
- Assert `reset` during DATA of the 2nd queued byte → `tx`=1 immediately; STATUS=0x0000_0002; no further frames are sent.
- Push to 0x0 on the same cycle as the STOP-end pop with count=2 → count stays 2, and byte order is preserved on the line.
